elevator_ctrl: RTL and testbench

Main elevator controller FSM. Latches hall/cabin calls and drives motor and door using a SCAN policy (keep direction while calls remain ahead). Publishes its state on `estado` to the downstream TIMEOUT dwell timer, and consumes that timer's `timeout` pulse to end door-open and door-close dwells.

---
 rtl/elevator_pkg.sv | 19 +
 rtl/elevator_ctrl_req_lookahead.sv | 28 ++
 rtl/elevator_ctrl.sv | 146 ++++++++++++++
 tb/tb_elevator_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator controller and its dwell timer.
package elevator_pkg;

   localparam int ESTADO_W = 3;

   // Controller state, also published to the TIMEOUT dwell timer
   typedef enum logic [ESTADO_W-1:0] {
      IDLE       = 3'd0,
      MOVE_UP    = 3'd1,
      MOVE_DOWN  = 3'd2,
      DOOR_OPEN  = 3'd3,
      DOOR_CLOSE = 3'd4
   } estado_t;

   // Dwell lengths consumed by TIMEOUT; the controller only sees its pulse
   localparam int DOOR_OPEN_CYCLES  = 8;
   localparam int DOOR_CLOSE_CYCLES = 4;

endpackage

// File: rtl/elevator_ctrl_req_lookahead.sv
// Combinational call lookahead: are there calls above, below or at a floor.
module req_lookahead
   import elevator_pkg::*;
#(
   parameter int N_FLOORS = 4,
   parameter int FLOOR_W  = $clog2(N_FLOORS)
) (
   input  logic [N_FLOORS-1:0] pending,
   input  logic [FLOOR_W-1:0]  cur_floor,
   output logic                above,
   output logic                below,
   output logic                here
);

   logic [N_FLOORS-1:0] m_above, m_below, m_here;

   // Per-floor masks against the reference floor; avoids variable part-selects
   for (genvar i = 0; i < N_FLOORS; i++) begin : g_floor
      assign m_above[i] = pending[i] & (FLOOR_W'(i) >  cur_floor);
      assign m_below[i] = pending[i] & (FLOOR_W'(i) <  cur_floor);
      assign m_here[i]  = pending[i] & (FLOOR_W'(i) == cur_floor);
   end

   assign above = |m_above;
   assign below = |m_below;
   assign here  = |m_here;

endmodule

// File: rtl/elevator_ctrl.sv
// SCAN elevator controller: call latch, sensor qualification and Moore FSM.
module elevator_ctrl
   import elevator_pkg::*;
#(
   parameter int N_FLOORS = 4,
   parameter int FLOOR_W  = $clog2(N_FLOORS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_FLOORS-1:0] req,
   input  logic [N_FLOORS-1:0] floor_sensor,
   input  logic                timeout,
   output logic [ESTADO_W-1:0] estado,
   output logic                motor_up,
   output logic                motor_down,
   output logic                door_open,
   output logic [N_FLOORS-1:0] pending,
   output logic [FLOOR_W-1:0]  cur_floor,
   output logic                dir_up
);

   estado_t             state, nxt, d_state;
   logic                dir_nxt, d_dir;
   logic [FLOOR_W-1:0]  sens_idx, clr_idx;
   logic                sens_one, arrive;
   logic [N_FLOORS-1:0] cur_oh, clr_oh, clr;
   logic                req_here;
   logic                above, below, here;
   logic                a_above, a_below, a_here;

   // Lookahead from the confirmed floor (decision D) and from the arriving floor
   req_lookahead #(.N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W)) u_cur (
      .pending   (pending),
      .cur_floor (cur_floor),
      .above     (above),
      .below     (below),
      .here      (here)
   );

   req_lookahead #(.N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W)) u_arr (
      .pending   (pending),
      .cur_floor (sens_idx),
      .above     (a_above),
      .below     (a_below),
      .here      (a_here)
   );

   // Sensor qualification: only a clean one-hot at a new floor is an arrival
   always_comb begin
      sens_idx = '0;
      for (int i = 0; i < N_FLOORS; i++)
         if (floor_sensor[i]) sens_idx = FLOOR_W'(i);
      sens_one = (floor_sensor != '0) &&
                 ((floor_sensor & (floor_sensor - N_FLOORS'(1))) == '0);
      arrive   = sens_one && (sens_idx != cur_floor);
   end

   // One-hot decodes of the current floor and the floor being cleared
   always_comb begin
      for (int i = 0; i < N_FLOORS; i++) begin
         cur_oh[i] = (cur_floor == FLOOR_W'(i));
         clr_oh[i] = (clr_idx   == FLOOR_W'(i));
      end
      req_here = |(req & cur_oh);
   end

   // Decision D: serve here, keep direction while calls ahead, else reverse
   always_comb begin
      d_state = IDLE;
      d_dir   = dir_up;
      if (here) begin
         d_state = DOOR_OPEN;
      end else if (dir_up) begin
         if (above) d_state = MOVE_UP;
         else if (below) begin
            d_state = MOVE_DOWN;
            d_dir   = 1'b0;
         end
      end else begin
         if (below) d_state = MOVE_DOWN;
         else if (above) begin
            d_state = MOVE_UP;
            d_dir   = 1'b1;
         end
      end
   end

   // Next-state logic; moves stop at calls or when nothing remains ahead
   always_comb begin
      nxt     = state;
      dir_nxt = dir_up;
      clr_idx = cur_floor;
      case (state)
         IDLE: begin
            nxt     = d_state;
            dir_nxt = d_dir;
         end
         MOVE_UP: if (arrive) begin
            clr_idx = sens_idx;
            if (a_here)        nxt = DOOR_OPEN;
            else if (!a_above) nxt = IDLE;
         end
         MOVE_DOWN: if (arrive) begin
            clr_idx = sens_idx;
            if (a_here)        nxt = DOOR_OPEN;
            else if (!a_below) nxt = IDLE;
         end
         DOOR_OPEN: if (timeout) nxt = DOOR_CLOSE;
         DOOR_CLOSE: begin
            // A call at this floor reopens even against a same-cycle timeout
            if (req_here) nxt = DOOR_OPEN;
            else if (timeout) begin
               nxt     = d_state;
               dir_nxt = d_dir;
            end
         end
         default: nxt = IDLE;
      endcase
      // Clearing while the door is (or is about to be) open absorbs local calls
      clr = ((nxt == DOOR_OPEN) || (state == DOOR_OPEN)) ? clr_oh : '0;
   end

   // State, call latch, floor tracking and registered Moore outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         pending    <= '0;
         cur_floor  <= '0;
         dir_up     <= 1'b1;
         motor_up   <= 1'b0;
         motor_down <= 1'b0;
         door_open  <= 1'b0;
      end else begin
         state      <= nxt;
         pending    <= (pending | req) & ~clr;
         dir_up     <= dir_nxt;
         if (arrive) cur_floor <= sens_idx;
         motor_up   <= (nxt == MOVE_UP);
         motor_down <= (nxt == MOVE_DOWN);
         door_open  <= (nxt == DOOR_OPEN);
      end
   end

   assign estado = state;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Scenario bench for elevator_ctrl with a queue of expected observations.
module tb_elevator_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] req, floor_sensor;
   logic       timeout;
   logic [2:0] estado;
   logic       motor_up, motor_down, door_open, dir_up;
   logic [3:0] pending;
   logic [1:0] cur_floor;

   int vecs   = 0;
   int misses = 0;

   logic [12:0] sbq[$];
   logic [12:0] obs;

   typedef struct packed {
      logic [3:0] rq;
      logic [3:0] sn;
      logic       to;
      logic [2:0] st;
      logic [3:0] pd;
      logic [1:0] cf;
      logic       du;
   } step_t;

   elevator_ctrl #(.N_FLOORS(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .floor_sensor (floor_sensor),
      .timeout      (timeout),
      .estado       (estado),
      .motor_up     (motor_up),
      .motor_down   (motor_down),
      .door_open    (door_open),
      .pending      (pending),
      .cur_floor    (cur_floor),
      .dir_up       (dir_up)
   );

   always #5 clk = ~clk;

   assign obs = {estado, motor_up, motor_down, door_open, pending, cur_floor, dir_up};

   // Expected observation: actuator bits follow from the state code
   function automatic logic [12:0] pk(logic [2:0] st, logic [3:0] pd, logic [1:0] cf, logic du);
      return {st, st == 3'd1, st == 3'd2, st == 3'd3, pd, cf, du};
   endfunction

   task automatic drive(input logic [3:0] r, input logic [3:0] s, input logic t);
      req = r; floor_sensor = s; timeout = t;
      @(posedge clk); #1;
      req = '0; timeout = 1'b0;
   endtask

   task automatic test_reset();
      logic [12:0] e;
      rst_n = 1'b0; req = '0; floor_sensor = 4'b0001; timeout = 1'b0;
      sbq.push_back(pk(3'd0, 4'b0000, 2'd0, 1'b1));
      @(posedge clk); #1;
      e = sbq.pop_front(); vecs++;
      if (obs !== e) begin misses++; $display("FAIL reset: got %h expected %h", obs, e); end
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         sbq.push_back(pk(3'd0, 4'b0000, 2'd0, 1'b1));
         drive(4'b0000, 4'b0001, 1'b0);
         e = sbq.pop_front(); vecs++;
         if (obs !== e) begin misses++; $display("FAIL reset_idle[%0d]: got %h expected %h", i, obs, e); end
      end
   endtask

   task automatic test_call_here();
      step_t t[5];
      logic [12:0] e;
      t = '{'{4'b0001, 4'b0001, 1'b0, 3'd0, 4'b0001, 2'd0, 1'b1},
            '{4'b0000, 4'b0001, 1'b0, 3'd3, 4'b0000, 2'd0, 1'b1},
            '{4'b0000, 4'b0001, 1'b0, 3'd3, 4'b0000, 2'd0, 1'b1},
            '{4'b0000, 4'b0001, 1'b1, 3'd4, 4'b0000, 2'd0, 1'b1},
            '{4'b0000, 4'b0001, 1'b1, 3'd0, 4'b0000, 2'd0, 1'b1}};
      foreach (t[i]) begin
         sbq.push_back(pk(t[i].st, t[i].pd, t[i].cf, t[i].du));
         drive(t[i].rq, t[i].sn, t[i].to);
         e = sbq.pop_front(); vecs++;
         if (obs !== e) begin misses++; $display("FAIL call_here[%0d]: got %h expected %h", i, obs, e); end
      end
   endtask

   task automatic test_travel_up();
      step_t t[8];
      logic [12:0] e;
      t = '{'{4'b0100, 4'b0001, 1'b0, 3'd0, 4'b0100, 2'd0, 1'b1},
            '{4'b0000, 4'b0001, 1'b0, 3'd1, 4'b0100, 2'd0, 1'b1},
            '{4'b0000, 4'b0000, 1'b0, 3'd1, 4'b0100, 2'd0, 1'b1},
            '{4'b0000, 4'b0010, 1'b0, 3'd1, 4'b0100, 2'd1, 1'b1},
            '{4'b0000, 4'b0000, 1'b1, 3'd1, 4'b0100, 2'd1, 1'b1},
            '{4'b0000, 4'b0100, 1'b0, 3'd3, 4'b0000, 2'd2, 1'b1},
            '{4'b0000, 4'b0100, 1'b1, 3'd4, 4'b0000, 2'd2, 1'b1},
            '{4'b0000, 4'b0100, 1'b1, 3'd0, 4'b0000, 2'd2, 1'b1}};
      foreach (t[i]) begin
         sbq.push_back(pk(t[i].st, t[i].pd, t[i].cf, t[i].du));
         drive(t[i].rq, t[i].sn, t[i].to);
         e = sbq.pop_front(); vecs++;
         if (obs !== e) begin misses++; $display("FAIL travel_up[%0d]: got %h expected %h", i, obs, e); end
      end
   endtask

   task automatic test_scan();
      step_t t[17];
      logic [12:0] e;
      t = '{'{4'b0010, 4'b0100, 1'b0, 3'd0, 4'b0010, 2'd2, 1'b1},
            '{4'b0000, 4'b0100, 1'b0, 3'd2, 4'b0010, 2'd2, 1'b0},
            '{4'b0000, 4'b0010, 1'b0, 3'd3, 4'b0000, 2'd1, 1'b0},
            '{4'b1000, 4'b0010, 1'b0, 3'd3, 4'b1000, 2'd1, 1'b0},
            '{4'b0000, 4'b0010, 1'b1, 3'd4, 4'b1000, 2'd1, 1'b0},
            '{4'b0000, 4'b0010, 1'b1, 3'd1, 4'b1000, 2'd1, 1'b1},
            '{4'b0001, 4'b0000, 1'b0, 3'd1, 4'b1001, 2'd1, 1'b1},
            '{4'b0000, 4'b0100, 1'b0, 3'd1, 4'b1001, 2'd2, 1'b1},
            '{4'b0000, 4'b0000, 1'b0, 3'd1, 4'b1001, 2'd2, 1'b1},
            '{4'b0000, 4'b1000, 1'b0, 3'd3, 4'b0001, 2'd3, 1'b1},
            '{4'b0000, 4'b1000, 1'b1, 3'd4, 4'b0001, 2'd3, 1'b1},
            '{4'b0000, 4'b1000, 1'b1, 3'd2, 4'b0001, 2'd3, 1'b0},
            '{4'b0000, 4'b0000, 1'b0, 3'd2, 4'b0001, 2'd3, 1'b0},
            '{4'b0000, 4'b0010, 1'b0, 3'd2, 4'b0001, 2'd1, 1'b0},
            '{4'b0000, 4'b0001, 1'b0, 3'd3, 4'b0000, 2'd0, 1'b0},
            '{4'b0000, 4'b0001, 1'b1, 3'd4, 4'b0000, 2'd0, 1'b0},
            '{4'b0000, 4'b0001, 1'b1, 3'd0, 4'b0000, 2'd0, 1'b0}};
      foreach (t[i]) begin
         sbq.push_back(pk(t[i].st, t[i].pd, t[i].cf, t[i].du));
         drive(t[i].rq, t[i].sn, t[i].to);
         e = sbq.pop_front(); vecs++;
         if (obs !== e) begin misses++; $display("FAIL scan[%0d]: got %h expected %h", i, obs, e); end
      end
   endtask

   task automatic test_reopen();
      step_t t[11];
      logic [12:0] e;
      t = '{'{4'b0100, 4'b0001, 1'b0, 3'd0, 4'b0100, 2'd0, 1'b0},
            '{4'b0000, 4'b0001, 1'b0, 3'd1, 4'b0100, 2'd0, 1'b1},
            '{4'b0000, 4'b0110, 1'b0, 3'd1, 4'b0100, 2'd0, 1'b1},
            '{4'b0000, 4'b0010, 1'b0, 3'd1, 4'b0100, 2'd1, 1'b1},
            '{4'b0000, 4'b0011, 1'b0, 3'd1, 4'b0100, 2'd1, 1'b1},
            '{4'b0000, 4'b0100, 1'b0, 3'd3, 4'b0000, 2'd2, 1'b1},
            '{4'b0100, 4'b0100, 1'b0, 3'd3, 4'b0000, 2'd2, 1'b1},
            '{4'b0000, 4'b0100, 1'b1, 3'd4, 4'b0000, 2'd2, 1'b1},
            '{4'b0100, 4'b0100, 1'b1, 3'd3, 4'b0000, 2'd2, 1'b1},
            '{4'b0000, 4'b0100, 1'b1, 3'd4, 4'b0000, 2'd2, 1'b1},
            '{4'b0000, 4'b0100, 1'b1, 3'd0, 4'b0000, 2'd2, 1'b1}};
      foreach (t[i]) begin
         sbq.push_back(pk(t[i].st, t[i].pd, t[i].cf, t[i].du));
         drive(t[i].rq, t[i].sn, t[i].to);
         e = sbq.pop_front(); vecs++;
         if (obs !== e) begin misses++; $display("FAIL reopen[%0d]: got %h expected %h", i, obs, e); end
      end
   endtask

   task automatic test_reset_mid_move();
      step_t t[2];
      logic [12:0] e;
      t = '{'{4'b0001, 4'b0100, 1'b0, 3'd0, 4'b0001, 2'd2, 1'b1},
            '{4'b0000, 4'b0100, 1'b0, 3'd2, 4'b0001, 2'd2, 1'b0}};
      foreach (t[i]) begin
         sbq.push_back(pk(t[i].st, t[i].pd, t[i].cf, t[i].du));
         drive(t[i].rq, t[i].sn, t[i].to);
         e = sbq.pop_front(); vecs++;
         if (obs !== e) begin misses++; $display("FAIL mid_move[%0d]: got %h expected %h", i, obs, e); end
      end
      // Drop reset between clock edges: motor must fall without a clock
      floor_sensor = 4'b0000;
      #2;
      sbq.push_back(pk(3'd0, 4'b0000, 2'd0, 1'b1));
      rst_n = 1'b0;
      #1;
      e = sbq.pop_front(); vecs++;
      if (obs !== e) begin misses++; $display("FAIL async_reset: got %h expected %h", obs, e); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         sbq.push_back(pk(3'd0, 4'b0000, 2'd0, 1'b1));
         drive(4'b0000, 4'b0001, 1'b0);
         e = sbq.pop_front(); vecs++;
         if (obs !== e) begin misses++; $display("FAIL post_reset[%0d]: got %h expected %h", i, obs, e); end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_call_here();
      test_travel_up();
      test_scan();
      test_reopen();
      test_reset_mid_move();
      if (sbq.size() != 0) begin
         misses++;
         $display("FAIL scoreboard: %0d entries left, expected 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, misses);
      $finish;
   end

endmodule
